ram_port_arbiter: RTL and testbench

Round-robin arbiter and command sequencer that shares the single-port SPI-attached RAM between two requesters (port 0: SPI slave path, port 1: local host). Each granted transaction is translated into the RAM's 10-bit command stream (`00` write address, `01` write data, `10` read address, `11` read data). For reads, the block captures the RAM's `tx_valid`/`dout` response and returns it to the owning port. The block sits between the requesters and the RAM's `din`/`rx_valid`/`dout`/`tx_valid` pins.

---
 rtl/ram_port_arbiter.sv | 169 ++++++++++++++++
 tb/tb_ram_port_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter that shares one SPI-attached RAM between two requesters and
// sequences each granted transaction into the RAM's 2-bit-opcode command stream.
module ram_port_arbiter #(
    parameter int ADDR_SIZE = 8,
    parameter int TIMEOUT   = 15
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req0,
    input  logic                 req1,
    input  logic                 we0,
    input  logic                 we1,
    input  logic [ADDR_SIZE-1:0] addr0,
    input  logic [ADDR_SIZE-1:0] addr1,
    input  logic [ADDR_SIZE-1:0] wdata0,
    input  logic [ADDR_SIZE-1:0] wdata1,
    output logic                 gnt0,
    output logic                 gnt1,
    output logic                 done0,
    output logic                 done1,
    output logic [ADDR_SIZE-1:0] rdata,
    output logic                 err,
    output logic                 busy,
    output logic [ADDR_SIZE+1:0] ram_din,
    output logic                 ram_rx_valid,
    input  logic [ADDR_SIZE-1:0] ram_dout,
    input  logic                 ram_tx_valid
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR,
        WR_DATA,
        RD_ADDR,
        RD_CMD,
        RD_WAIT,
        DONE
    } state_t;

    state_t               state;
    state_t               state_next;
    logic                 owner;
    logic                 last_served;
    logic                 we_q;
    logic [ADDR_SIZE-1:0] addr_q;
    logic [ADDR_SIZE-1:0] wdata_q;
    logic [CNT_W-1:0]     wait_cnt;

    logic                 grant_valid;
    logic                 winner;
    logic                 win_we;
    logic [ADDR_SIZE-1:0] win_addr;
    logic [ADDR_SIZE-1:0] win_wdata;
    logic                 read_hit;
    logic                 timeout_hit;
    logic                 enter_done;

    // On a tie the port that was not served last wins; otherwise the lone requester.
    assign grant_valid = (state == IDLE) && (req0 || req1);
    assign winner      = (req0 && req1) ? ~last_served : req1;
    assign win_we      = winner ? we1 : we0;
    assign win_addr    = winner ? addr1 : addr0;
    assign win_wdata   = winner ? wdata1 : wdata0;

    assign read_hit    = (state == RD_WAIT) && ram_tx_valid;
    assign timeout_hit = (state == RD_WAIT) && !ram_tx_valid && (wait_cnt == CNT_LAST);
    assign enter_done  = (state_next == DONE);
    assign busy        = (state != IDLE);

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (grant_valid) state_next = win_we ? WR_ADDR : RD_ADDR;
            WR_ADDR: state_next = WR_DATA;
            WR_DATA: state_next = DONE;
            RD_ADDR: state_next = RD_CMD;
            RD_CMD:  state_next = RD_WAIT;
            RD_WAIT: if (read_hit || timeout_hit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The address phase opcode differs only in its top bit between write and read.
    always_comb begin
        ram_din      = '0;
        ram_rx_valid = 1'b0;
        unique case (state)
            WR_ADDR, RD_ADDR: begin
                ram_rx_valid = 1'b1;
                ram_din      = {~we_q, 1'b0, addr_q};
            end
            WR_DATA: begin
                ram_rx_valid = 1'b1;
                ram_din      = {2'b01, wdata_q};
            end
            RD_CMD: begin
                ram_rx_valid = 1'b1;
                ram_din      = {2'b11, {ADDR_SIZE{1'b0}}};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
        end else begin
            gnt0 <= grant_valid && !winner;
            gnt1 <= grant_valid && winner;
            if (grant_valid) begin
                owner   <= winner;
                we_q    <= win_we;
                addr_q  <= win_addr;
                wdata_q <= win_wdata;
            end
        end
    end

    // Counter sits at zero outside RD_WAIT so it is already cleared on entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (state == RD_WAIT) begin
            wait_cnt <= wait_cnt + 1'b1;
        end else begin
            wait_cnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done0       <= 1'b0;
            done1       <= 1'b0;
            err         <= 1'b0;
            rdata       <= '0;
            last_served <= 1'b1;
        end else begin
            done0 <= enter_done && !owner;
            done1 <= enter_done && owner;
            err   <= timeout_hit;
            if (read_hit) begin
                rdata <= ram_dout;
            end else if (timeout_hit) begin
                rdata <= '0;
            end
            if (state == DONE) begin
                last_served <= owner;
            end
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench for ram_port_arbiter: RAM command words and completions are
// queued when stimulus is issued and checked by free-running monitors.
module tb_ram_port_arbiter;

    localparam int AW  = 8;
    localparam int TMO = 15;

    typedef struct packed {
        logic          port;
        logic          err;
        logic [AW-1:0] rdata;
    } done_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req0, req1, we0, we1;
    logic [AW-1:0] addr0, addr1, wdata0, wdata1;
    logic          gnt0, gnt1, done0, done1, err, busy;
    logic [AW-1:0] rdata;
    logic [AW+1:0] ram_din;
    logic          ram_rx_valid;
    logic [AW-1:0] ram_dout;
    logic          ram_tx_valid;

    logic          model_tx = 1'b0;
    logic          stray_tx = 1'b0;
    logic          ram_mute = 1'b0;
    logic [AW-1:0] mem [256];
    logic [AW-1:0] wr_ptr, rd_ptr;

    logic [AW+1:0] exp_cmd[$];
    done_t         exp_done[$];
    int            n_vectors = 0;
    int            n_miscompares = 0;

    assign ram_tx_valid = model_tx | stray_tx;

    always #5 clk = ~clk;

    ram_port_arbiter #(.ADDR_SIZE(AW), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .rdata(rdata), .err(err), .busy(busy),
        .ram_din(ram_din), .ram_rx_valid(ram_rx_valid),
        .ram_dout(ram_dout), .ram_tx_valid(ram_tx_valid)
    );

    // RAM model: responds one edge after the read-data command, unless muted.
    always @(posedge clk) begin
        model_tx <= 1'b0;
        if (ram_rx_valid) begin
            case (ram_din[AW+1:AW])
                2'b00: wr_ptr <= ram_din[AW-1:0];
                2'b01: mem[wr_ptr] <= ram_din[AW-1:0];
                2'b10: rd_ptr <= ram_din[AW-1:0];
                default: if (!ram_mute) begin
                    model_tx <= 1'b1;
                    ram_dout <= mem[rd_ptr];
                end
            endcase
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_vectors++;
        if (actual !== expected) begin
            n_miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(posedge clk) begin : cmd_monitor
        logic [AW+1:0] e;
        #1;
        if (rst_n && ram_rx_valid) begin
            if (exp_cmd.size() == 0) begin
                n_vectors++;
                n_miscompares++;
                $display("[TB] FAIL unexpected_cmd: got 0x%0h, want none at %0t", ram_din, $time);
            end else begin
                e = exp_cmd.pop_front();
                checkOutput("ram_din", 32'(ram_din), 32'(e));
            end
        end
    end

    always @(posedge clk) begin : done_monitor
        done_t d;
        #1;
        if (rst_n && (done0 || done1)) begin
            if (exp_done.size() == 0) begin
                n_vectors++;
                n_miscompares++;
                $display("[TB] FAIL unexpected_done: got done0=%0b done1=%0b, want none at %0t",
                         done0, done1, $time);
            end else begin
                d = exp_done.pop_front();
                checkOutput("done_onehot", 32'(done0 & done1), 32'd0);
                checkOutput("done_port", 32'(done1), 32'(d.port));
                checkOutput("done_err", 32'(err), 32'(d.err));
                checkOutput("done_rdata", 32'(rdata), 32'(d.rdata));
            end
        end
    end

    task automatic pushWrite(input logic port, input logic [AW-1:0] addr,
                             input logic [AW-1:0] wdata, input logic [AW-1:0] rd_exp);
        done_t d;
        exp_cmd.push_back({2'b00, addr});
        exp_cmd.push_back({2'b01, wdata});
        d.port = port; d.err = 1'b0; d.rdata = rd_exp;
        exp_done.push_back(d);
    endtask

    task automatic pushRead(input logic port, input logic [AW-1:0] addr,
                            input logic err_exp, input logic [AW-1:0] rd_exp);
        done_t d;
        exp_cmd.push_back({2'b10, addr});
        exp_cmd.push_back({2'b11, {AW{1'b0}}});
        d.port = port; d.err = err_exp; d.rdata = rd_exp;
        exp_done.push_back(d);
    endtask

    task automatic applyStimulus(input logic port, input logic we,
                                 input logic [AW-1:0] addr, input logic [AW-1:0] wdata);
        @(negedge clk);
        if (port) begin
            req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wdata;
        end else begin
            req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wdata;
        end
    endtask

    // Cycle 1 is the grant cycle; exp_cycles is the cycle in which done must appear.
    task automatic runTxn(input logic port, input logic we, input logic [AW-1:0] addr,
                          input logic [AW-1:0] wdata, input int exp_cycles,
                          input logic stray_in_addr);
        int cycles;
        applyStimulus(port, we, addr, wdata);
        @(posedge clk); #1;
        checkOutput(port ? "gnt1" : "gnt0", 32'(port ? gnt1 : gnt0), 32'd1);
        checkOutput("gnt_other", 32'(port ? gnt0 : gnt1), 32'd0);
        req0 = 1'b0;
        req1 = 1'b0;
        if (stray_in_addr) stray_tx = 1'b1;
        cycles = 1;
        while (!(done0 || done1) && cycles < 60) begin
            @(posedge clk); #1;
            stray_tx = 1'b0;
            cycles++;
        end
        checkOutput("done_latency", 32'(cycles), 32'(exp_cycles));
        @(posedge clk); #1;
        checkOutput("idle_after_done", 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit order [4];
        int k;
        order = '{1'b0, 1'b1, 1'b0, 1'b1};
        rst_n = 1'b0;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        @(posedge clk); #1;
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_gnt", 32'({gnt0, gnt1}), 32'd0);
        checkOutput("rst_done", 32'({done0, done1}), 32'd0);
        checkOutput("rst_err", 32'(err), 32'd0);
        checkOutput("rst_rdata", 32'(rdata), 32'd0);
        checkOutput("rst_ram_din", 32'(ram_din), 32'd0);
        checkOutput("rst_rx_valid", 32'(ram_rx_valid), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] single write / single read");
        pushWrite(1'b0, 8'h28, 8'h5A, 8'h00);
        runTxn(1'b0, 1'b1, 8'h28, 8'h5A, 3, 1'b0);
        pushRead(1'b1, 8'h28, 1'b0, 8'h5A);
        runTxn(1'b1, 1'b0, 8'h28, 8'h00, 4, 1'b0);
        checkOutput("rdata_hold", 32'(rdata), 32'h5A);

        $display("[TB] stray responses");
        @(negedge clk); stray_tx = 1'b1;
        @(negedge clk); stray_tx = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("stray_idle_busy", 32'(busy), 32'd0);
        checkOutput("stray_idle_rdata", 32'(rdata), 32'h5A);
        pushWrite(1'b1, 8'h10, 8'h33, 8'h5A);
        runTxn(1'b1, 1'b1, 8'h10, 8'h33, 3, 1'b1);
        checkOutput("stray_wr_rdata", 32'(rdata), 32'h5A);

        $display("[TB] read timeout");
        ram_mute = 1'b1;
        pushRead(1'b0, 8'h28, 1'b1, 8'h00);
        runTxn(1'b0, 1'b0, 8'h28, 8'h00, 3 + TMO, 1'b0);
        ram_mute = 1'b0;
        checkOutput("timeout_rdata", 32'(rdata), 32'd0);
        checkOutput("err_cleared", 32'(err), 32'd0);

        $display("[TB] reset mid-transaction");
        exp_cmd.push_back(10'h044);
        exp_cmd.push_back(10'h199);
        applyStimulus(1'b0, 1'b1, 8'h44, 8'h99);
        @(posedge clk); #1;
        checkOutput("mid_gnt0", 32'(gnt0), 32'd1);
        req0 = 1'b0;
        @(posedge clk); #1;
        checkOutput("mid_wr_data_valid", 32'(ram_rx_valid), 32'd1);
        @(negedge clk); rst_n = 1'b0;
        #1;
        checkOutput("mid_rx_valid_drop", 32'(ram_rx_valid), 32'd0);
        checkOutput("mid_ram_din", 32'(ram_din), 32'd0);
        checkOutput("mid_busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("mid_no_done", 32'({done0, done1}), 32'd0);
        pushWrite(1'b0, 8'h50, 8'hA5, 8'h00);
        runTxn(1'b0, 1'b1, 8'h50, 8'hA5, 3, 1'b0);

        $display("[TB] simultaneous requests from reset");
        @(negedge clk); rst_n = 1'b0;
        req0 = 1'b1; we0 = 1'b1; addr0 = 8'h01; wdata0 = 8'h11;
        req1 = 1'b1; we1 = 1'b0; addr1 = 8'h10; wdata1 = 8'h00;
        pushWrite(1'b0, 8'h01, 8'h11, 8'h00);
        pushRead(1'b1, 8'h10, 1'b0, 8'h33);
        pushWrite(1'b0, 8'h01, 8'h11, 8'h33);
        pushRead(1'b1, 8'h10, 1'b0, 8'h33);
        @(negedge clk); rst_n = 1'b1;
        k = 0;
        for (int c = 0; c < 200 && k < 4; c++) begin
            @(posedge clk); #1;
            if (gnt0 || gnt1) begin
                checkOutput("gnt_exclusive", 32'(gnt0 & gnt1), 32'd0);
                checkOutput("gnt_order", 32'(gnt1), 32'(order[k]));
                k++;
                if (k == 4) begin
                    req0 = 1'b0;
                    req1 = 1'b0;
                end
            end
        end
        checkOutput("gnt_count", 32'(k), 32'd4);
        req0 = 1'b0;
        req1 = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(posedge clk); #1;
            if (!busy) break;
        end
        repeat (3) @(posedge clk);
        #1;

        checkOutput("cmd_queue_empty", 32'(exp_cmd.size()), 32'd0);
        checkOutput("done_queue_empty", 32'(exp_done.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
